// File: rtl/cordic_sequencer.sv
// rtl/cordic_sequencer.sv - iterative CORDIC sequencer around one combinational micro-rotation stage
module cordic #(
    parameter int p_WIDTH = 32,
    parameter int p_SW    = 5
) (
    input  logic [p_WIDTH-1:0] xPrev,
    input  logic [p_WIDTH-1:0] yPrev,
    input  logic [p_WIDTH-1:0] zPrev,
    input  logic [p_SW-1:0]    shiftAmount,
    input  logic [p_WIDTH-1:0] rotationAngle,
    input  logic               rotationDir,
    input  logic               rotationSystem,
    output logic [p_WIDTH-1:0] xResult,
    output logic [p_WIDTH-1:0] yResult,
    output logic [p_WIDTH-1:0] zResult,
    output logic               xOverflow,
    output logic               yOverflow,
    output logic               zOverflow
);
    logic [p_WIDTH-1:0] xs;
    logic [p_WIDTH-1:0] ys;
    logic [p_WIDTH:0]   xw;
    logic [p_WIDTH:0]   yw;
    logic [p_WIDTH:0]   zw;
    logic               sub_x;

    assign xs = $signed(xPrev) >>> shiftAmount;
    assign ys = $signed(yPrev) >>> shiftAmount;

    // circular subtracts y on a positive rotation, hyperbolic adds it
    assign sub_x = (rotationDir == rotationSystem);

    always_comb begin
        if (sub_x) xw = {xPrev[p_WIDTH-1], xPrev} - {ys[p_WIDTH-1], ys};
        else       xw = {xPrev[p_WIDTH-1], xPrev} + {ys[p_WIDTH-1], ys};
        if (rotationDir) begin
            yw = {yPrev[p_WIDTH-1], yPrev} + {xs[p_WIDTH-1], xs};
            zw = {zPrev[p_WIDTH-1], zPrev} - {rotationAngle[p_WIDTH-1], rotationAngle};
        end else begin
            yw = {yPrev[p_WIDTH-1], yPrev} - {xs[p_WIDTH-1], xs};
            zw = {zPrev[p_WIDTH-1], zPrev} + {rotationAngle[p_WIDTH-1], rotationAngle};
        end
    end

    assign xResult   = xw[p_WIDTH-1:0];
    assign yResult   = yw[p_WIDTH-1:0];
    assign zResult   = zw[p_WIDTH-1:0];
    assign xOverflow = xw[p_WIDTH] ^ xw[p_WIDTH-1];
    assign yOverflow = yw[p_WIDTH] ^ yw[p_WIDTH-1];
    assign zOverflow = zw[p_WIDTH] ^ zw[p_WIDTH-1];
endmodule

module cordic_sequencer #(
    parameter int p_WIDTH = 32,
    parameter int p_FRAC  = 16,
    parameter int p_ITER  = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               inValid,
    output logic               inReady,
    input  logic               mode,
    input  logic               system,
    input  logic [p_WIDTH-1:0] xIn,
    input  logic [p_WIDTH-1:0] yIn,
    input  logic [p_WIDTH-1:0] zIn,
    output logic               outValid,
    input  logic               outReady,
    output logic [p_WIDTH-1:0] xOut,
    output logic [p_WIDTH-1:0] yOut,
    output logic [p_WIDTH-1:0] zOut,
    output logic               overflow
);
    localparam int SW    = $clog2(p_WIDTH);
    localparam int KW    = $clog2(p_ITER + 1);
    localparam int ROM_N = 1 << SW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [p_WIDTH-1:0] x;
    logic [p_WIDTH-1:0] y;
    logic [p_WIDTH-1:0] z;
    logic               mode_q;
    logic               system_q;
    logic [KW-1:0]      k;
    logic [SW-1:0]      shiftAmount;
    logic               rep;
    logic [p_WIDTH-1:0] rotationAngle;
    logic               rotationDir;
    logic [p_WIDTH-1:0] xResult;
    logic [p_WIDTH-1:0] yResult;
    logic [p_WIDTH-1:0] zResult;
    logic               xOverflow;
    logic               yOverflow;
    logic               zOverflow;

    function automatic logic [p_WIDTH-1:0] rom_entry(input logic circ, input int s);
        real t;
        real a;
        t = 2.0 ** (-s);
        if (circ)        a = $atan(t);
        else if (s == 0) a = 0.0;
        else             a = $atanh(t);
        return p_WIDTH'($rtoi(a * (2.0 ** p_FRAC) + 0.5));
    endfunction

    // hyperbolic convergence needs shifts 4, 13, 40 visited twice
    function automatic logic is_repeat(input logic [SW-1:0] v);
        return (int'(v) == 4) || (int'(v) == 13) || (int'(v) == 40);
    endfunction

    logic [p_WIDTH-1:0] rom_circ [ROM_N];
    logic [p_WIDTH-1:0] rom_hyp  [ROM_N];

    for (genvar i = 0; i < ROM_N; i++) begin : g_rom
        localparam logic [p_WIDTH-1:0] C_CIRC = rom_entry(1'b1, i);
        localparam logic [p_WIDTH-1:0] C_HYP  = rom_entry(1'b0, i);
        assign rom_circ[i] = C_CIRC;
        assign rom_hyp[i]  = C_HYP;
    end

    assign rotationAngle = system_q ? rom_circ[shiftAmount] : rom_hyp[shiftAmount];
    assign rotationDir   = mode_q ? y[p_WIDTH-1] : ~z[p_WIDTH-1];

    cordic #(
        .p_WIDTH (p_WIDTH),
        .p_SW    (SW)
    ) u_cordic (
        .xPrev          (x),
        .yPrev          (y),
        .zPrev          (z),
        .shiftAmount    (shiftAmount),
        .rotationAngle  (rotationAngle),
        .rotationDir    (rotationDir),
        .rotationSystem (system_q),
        .xResult        (xResult),
        .yResult        (yResult),
        .zResult        (zResult),
        .xOverflow      (xOverflow),
        .yOverflow      (yOverflow),
        .zOverflow      (zOverflow)
    );

    always_comb begin
        state_nxt = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        case (state)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) state_nxt = RUN;
            end
            RUN: begin
                if (k == KW'(p_ITER - 1)) state_nxt = DONE;
            end
            DONE: begin
                outValid = 1'b1;
                if (outReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            mode_q      <= 1'b0;
            system_q    <= 1'b0;
            k           <= '0;
            shiftAmount <= '0;
            rep         <= 1'b0;
            xOut        <= '0;
            yOut        <= '0;
            zOut        <= '0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (inValid) begin
                        x           <= xIn;
                        y           <= yIn;
                        z           <= zIn;
                        mode_q      <= mode;
                        system_q    <= system;
                        overflow    <= 1'b0;
                        k           <= '0;
                        shiftAmount <= {{(SW-1){1'b0}}, ~system};
                        rep         <= 1'b0;
                    end
                end
                RUN: begin
                    x        <= xResult;
                    y        <= yResult;
                    z        <= zResult;
                    overflow <= overflow | xOverflow | yOverflow | zOverflow;
                    k        <= k + KW'(1);
                    if (!system_q && is_repeat(shiftAmount) && !rep) begin
                        rep <= 1'b1;
                    end else begin
                        rep         <= 1'b0;
                        shiftAmount <= shiftAmount + SW'(1);
                    end
                    if (k == KW'(p_ITER - 1)) begin
                        xOut <= xResult;
                        yOut <= yResult;
                        zOut <= zResult;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
